// File: rtl/pic_cycle_sequencer.sv
// Four-phase (Q1..Q4) instruction-cycle controller for a PIC16-style core.
// Holds the prefetched instruction register, resolves control flow and owns the return stack.
module pic_cycle_sequencer #(
    parameter int STACK_DEPTH = 8,
    parameter int PC_W        = 13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic [13:0]     instr,
    input  logic [PC_W-1:0] pc_value,
    input  logic [1:0]      pclath_hi,
    input  logic            skip_cond,
    output logic [1:0]      phase,
    output logic            imem_en,
    output logic            pc_inc,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_target,
    output logic            alu_en,
    output logic            wr_w,
    output logic            wr_f,
    output logic [13:0]     ir_out,
    output logic            flushing,
    output logic            stk_ovf,
    output logic            stk_unf
);

    localparam int SP_W  = $clog2(STACK_DEPTH);
    localparam int OCC_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0]  SP_ONE   = SP_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(STACK_DEPTH);
    localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } phase_t;

    phase_t            phase_q, phase_d;
    logic [13:0]       ir_q, next_ir_q;
    logic              flush_q;
    logic [SP_W-1:0]   sp_q;
    logic [OCC_W-1:0]  occ_q;
    logic              ovf_q, unf_q;
    logic [PC_W-1:0]   stack_mem [STACK_DEPTH];

    logic              active;
    logic              dec_wr_w, dec_wr_f, dec_skip;
    logic              is_call, is_goto, is_ret;
    logic              do_push, do_pop, flush_req;
    logic [12:0]       jump_addr;
    logic [SP_W-1:0]   pop_idx;

    assign active    = !reset && !hold;
    assign jump_addr = {pclath_hi, ir_q[10:0]};
    assign pop_idx   = sp_q - SP_ONE;
    assign is_call   = (ir_q[13:11] == 3'b100);
    assign is_goto   = (ir_q[13:11] == 3'b101);
    // RETLW loads W as well as returning; its write comes from the 11_xxxx class
    assign is_ret    = (ir_q == 14'h0008) || (ir_q[13:10] == 4'b1101);

    always_comb begin
        dec_wr_w = 1'b0;
        dec_wr_f = 1'b0;
        dec_skip = 1'b0;
        case (ir_q[13:12])
            2'b00: begin
                if (ir_q[11:8] == 4'h0) begin
                    dec_wr_f = ir_q[7];
                end else begin
                    dec_wr_f = ir_q[7];
                    dec_wr_w = !ir_q[7];
                    dec_skip = (ir_q[11:8] == 4'hB) || (ir_q[11:8] == 4'hF);
                end
            end
            2'b01: begin
                dec_wr_f = !ir_q[11];
                dec_skip = ir_q[11];
            end
            2'b10: ;
            default: dec_wr_w = 1'b1;
        endcase
    end

    always_comb begin
        phase_d   = phase_q;
        imem_en   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_target = '0;
        alu_en    = 1'b0;
        wr_w      = 1'b0;
        wr_f      = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        flush_req = 1'b0;
        if (active) begin
            case (phase_q)
                Q1: begin
                    imem_en = 1'b1;
                    phase_d = Q2;
                end
                Q2: begin
                    pc_inc  = 1'b1;
                    phase_d = Q3;
                end
                Q3: begin
                    alu_en  = !flush_q;
                    phase_d = Q4;
                end
                default: begin
                    phase_d = Q1;
                    if (!flush_q) begin
                        wr_w = dec_wr_w;
                        wr_f = dec_wr_f;
                        if (is_goto || is_call) begin
                            pc_load   = 1'b1;
                            pc_target = PC_W'(jump_addr);
                            do_push   = is_call;
                            flush_req = 1'b1;
                        end else if (is_ret) begin
                            pc_load   = 1'b1;
                            pc_target = stack_mem[pop_idx];
                            do_pop    = 1'b1;
                            flush_req = 1'b1;
                        end else if (dec_skip && skip_cond) begin
                            flush_req = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q   <= Q1;
            ir_q      <= '0;
            next_ir_q <= '0;
            flush_q   <= 1'b0;
            sp_q      <= '0;
            occ_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else if (!hold) begin
            phase_q <= phase_d;
            if (phase_q == Q2)
                next_ir_q <= instr;
            if (phase_q == Q4) begin
                ir_q    <= flush_req ? 14'h0000 : next_ir_q;
                flush_q <= flush_req;
            end
            if (do_push) begin
                sp_q <= sp_q + SP_ONE;
                if (occ_q == OCC_FULL)
                    ovf_q <= 1'b1;
                else
                    occ_q <= occ_q + OCC_ONE;
            end
            if (do_pop) begin
                sp_q <= pop_idx;
                if (occ_q == '0)
                    unf_q <= 1'b1;
                else
                    occ_q <= occ_q - OCC_ONE;
            end
        end
    end

    // Stack storage is deliberately left unreset; PC has advanced twice past the CALL
    always_ff @(posedge clk) begin
        if (do_push)
            stack_mem[sp_q] <= pc_value - PC_ONE;
    end

    assign phase    = phase_q;
    assign ir_out   = ir_q;
    assign flushing = flush_q;
    assign stk_ovf  = ovf_q;
    assign stk_unf  = unf_q;

endmodule

// File: doc/pic_cycle_sequencer.md
Name: pic_cycle_sequencer

Overview:
- Four-phase (Q1–Q4) instruction-cycle controller for the PIC16-style core.
- Drives the program counter, instruction memory, ALU, W register and file-register enables.
- Holds the 14-bit instruction register with one-instruction prefetch, resolves GOTO/CALL/RETURN/RETLW and conditional skips, and owns the hardware return stack.

Parameters:
STACK_DEPTH, 8, return-stack entries (power of two, ≥2)
PC_W, 13, program-counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
hold  in  1  freeze phase counter and all state
instr  in  14  instruction-memory read data (registered memory, valid one cycle after imem_en)
pc_value  in  PC_W  current PC from program counter
pclath_hi  in  2  upper target bits for GOTO/CALL
skip_cond  in  1  datapath skip condition (already polarity-resolved), sampled in Q4
phase  out  2  current phase, 0=Q1..3=Q4
imem_en  out  1  instruction-memory read enable
pc_inc  out  1  PC increment strobe
pc_load  out  1  PC load strobe
pc_target  out  PC_W  PC load value
alu_en  out  1  ALU clock enable
wr_w  out  1  W register write enable
wr_f  out  1  file register write enable
ir_out  out  14  instruction currently executing
flushing  out  1  current cycle executes a forced NOP
stk_ovf  out  1  sticky overflow flag
stk_unf  out  1  sticky underflow flag

Behaviour:
Reset:
- Async reset sets phase=Q1, ir=0, next_ir=0, flush=0, sp=0, stk_ovf=0, stk_unf=0.
- All strobes are forced 0 while reset is high.
- Stack contents are not reset.

Phase counter:
- Q1→Q2→Q3→Q4→Q1 each clk when hold=0.
- hold=1: phase, ir, next_ir, sp and flags are unchanged; all strobes are 0.
- reset has priority over hold.

Strobes (combinational from phase/ir, gated by !reset & !hold):
- Q1: imem_en=1.
- Q2: pc_inc=1; next_ir<=instr at end of Q2.
- Q3: alu_en=1 unless flushing.
- Q4: writeback and control-flow resolution. At end of Q4, ir<=next_ir, or ir<=0 (NOP) if a flush is required; flush<=that decision.

Decode of ir (all writebacks suppressed when flush=1):
- 00_0000_1fff_ffff (MOVWF): wr_f.
- 00_0001_0xxx_xxxx (CLRW): wr_w.
- Other 00_oooo_dfff_ffff with oooo≠0000: d=1→wr_f, d=0→wr_w.
- 00_0000_0xxx_xxxx other than RETURN: NOP, no write.
- 01_00/01 (BCF/BSF): wr_f. 01_10/11 (BTFSC/BTFSS): no write, skip candidate.
- 00_1011 (DECFSZ), 00_1111 (INCFSZ): write per d, and skip candidate.
- 11_xxxx: wr_w.
- 10_0kkk (CALL), 10_1kkk (GOTO), 00_0000_0000_1000 (RETURN), 11_01xx (RETLW, wr_w too).

Q4 control flow:
- GOTO: pc_load=1, pc_target={pclath_hi, ir[10:0]}; flush next cycle.
- CALL: same as GOTO, plus push pc_value−1 (return address = CALL address+1, because PC has advanced twice).
- RETURN/RETLW: pop; pc_load=1, pc_target=popped entry; flush.
- Skip candidate with skip_cond=1: no pc_load; flush. With skip_cond=0: no flush.
- Flushed cycle: executes no control flow and no push/pop; its own flush decision is 0.

Stack:
- Circular, sp is log2(STACK_DEPTH) bits; push writes stack[sp], sp+1; pop reads stack[sp−1], sp−1.
- Occupancy counter 0..STACK_DEPTH. Push at full: wraps (overwrites oldest) and sets stk_ovf. Pop at empty: wraps, returns stale entry and sets stk_unf.
- Flags are sticky until reset.

Test Plan:
- Reset mid-Q3, then release: phase=Q1, all strobes 0 during reset; ir_out=0; first imem_en on the first Q1 after release; pc_inc on the next cycle.
- Linear code: ADDWF 0x20,1 (0x07A0) at addr 0 → wr_f=1 in Q4 of instruction cycle 1, wr_w=0; alu_en in Q3; flushing=0.
- GOTO 0x155 (0x2955) with pclath_hi=2'b01 → Q4 pc_load=1, pc_target=0x0955; next cycle flushing=1 with no wr_w/wr_f/alu_en.
- CALL at 0x010, then RETURN → push 0x011; RETURN Q4 pc_target=0x011; both followed by a flushed cycle.
- DECFSZ 0x30,1 with skip_cond=1 → wr_f=1, no pc_load, next cycle flushed; repeat with skip_cond=0 → no flush.
- 9 CALLs with STACK_DEPTH=8 → stk_ovf=1 after the 9th; 9 RETURNs → 9th returns the 9th CALL's entry and stk_unf=1. hold=1 held for 5 cycles mid-Q2 → phase is frozen and the sequence resumes unchanged.
